fsfifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one full-synchronous FIFO write port among

---
 rtl/fsfifo_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_fsfifo_wr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsfifo_wr_arbiter.sv
// Round-robin write arbiter with bounded burst locking in front of one fsfifo write port.
// Optional per-requester accepted-beat counters when FSFIFO_ARB_STATS_EN is defined.
module fsfifo_wr_arbiter #(
   parameter  int unsigned NREQ      = 4,
   parameter  int unsigned WIDTH     = 32,
   parameter  int unsigned MAX_BURST = 4,
   localparam int unsigned IDW       = $clog2(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic                  fifo_full_i,
   output logic                  fifo_wr_o,
   output logic [IDW+WIDTH-1:0]  fifo_wr_data_o,
   output logic [IDW-1:0]        grant_id_o,
   output logic                  locked_o
`ifdef FSFIFO_ARB_STATS_EN
   ,
   input  logic                  stats_clr_i,
   output logic [NREQ*16-1:0]    grant_cnt_o
`endif
);

   localparam int unsigned BCW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [BCW-1:0]   beat_q, beat_d;
   logic [IDW-1:0]   scan_sel;
   logic [IDW-1:0]   sel;
   logic             sel_valid;
   logic             xfer;
   logic [WIDTH-1:0] data_arr [NREQ];

   function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
      return (32'(x) == NREQ - 1) ? '0 : IDW'(32'(x) + 32'd1);
   endfunction

   for (genvar k = 0; k < NREQ; k++) begin : g_data
      assign data_arr[k] = req_data_i[k*WIDTH +: WIDTH];
   end

   // First valid requester at or after rr_ptr, wrapping; falls back to rr_ptr.
   always_comb begin
      logic        found;
      int unsigned idx;
      scan_sel = rr_ptr_q;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NREQ;
         if (!found && req_valid_i[IDW'(idx)]) begin
            scan_sel = IDW'(idx);
            found    = 1'b1;
         end
      end
   end

   assign sel       = (state_q == ST_LOCKED) ? owner_q : scan_sel;
   assign sel_valid = req_valid_i[sel];
   assign xfer      = reset_ni & sel_valid & ~fifo_full_i;

   assign fifo_wr_o      = xfer;
   assign req_ready_o    = (reset_ni && !fifo_full_i) ? (NREQ'(1) << sel) : '0;
   assign grant_id_o     = reset_ni ? sel : '0;
   assign fifo_wr_data_o = reset_ni ? {sel, data_arr[sel]} : '0;
   assign locked_o       = reset_ni && (state_q == ST_LOCKED);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_OPEN;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         beat_q   <= beat_d;
      end
   end

   // Everything holds while the FIFO is full so the selection never moves.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      beat_d   = beat_q;
      if (!fifo_full_i) begin
         if (state_q == ST_LOCKED) begin
            if (!sel_valid || (32'(beat_q) + 32'd1 >= MAX_BURST)) begin
               state_d  = ST_OPEN;
               beat_d   = '0;
               rr_ptr_d = inc_mod(owner_q);
            end else begin
               beat_d = beat_q + BCW'(1);
            end
         end else if (sel_valid) begin
            owner_d = sel;
            beat_d  = BCW'(1);
            if (MAX_BURST > 1) begin
               state_d = ST_LOCKED;
            end else begin
               rr_ptr_d = inc_mod(sel);
            end
         end
      end
   end

`ifdef FSFIFO_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   // Saturating accepted-beat counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int unsigned k = 0; k < NREQ; k++) cnt_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (stats_clr_i) begin
               cnt_q[k] <= '0;
            end else if (req_valid_i[k] && req_ready_o[k] && (cnt_q[k] != 16'hFFFF)) begin
               cnt_q[k] <= cnt_q[k] + 16'd1;
            end
         end
      end
   end

   for (genvar k = 0; k < NREQ; k++) begin : g_cnt
      assign grant_cnt_o[k*16 +: 16] = cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_fsfifo_wr_arbiter.sv
// Scoreboard bench for fsfifo_wr_arbiter: a MAX_BURST=4 instance plus a MAX_BURST=1 instance.
module tb_fsfifo_wr_arbiter;

   logic         clk_i = 1'b0;
   logic         reset_ni;
   logic [3:0]   req_valid;
   logic [3:0]   rr_valid;
   logic [127:0] req_data;
   logic         fifo_full;
   logic         rr_full;
   logic         stats_clr;

   logic [3:0]   ready, rr_ready;
   logic         fifo_wr, rr_wr;
   logic [33:0]  wr_data, rr_data;
   logic [1:0]   grant, rr_grant;
   logic         locked, rr_locked;
`ifdef FSFIFO_ARB_STATS_EN
   logic [63:0]  cnt, rr_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int seq    = 0;
   logic [33:0] q  [$];
   logic [33:0] q1 [$];

   always #5 clk_i = ~clk_i;

   fsfifo_wr_arbiter #(.NREQ(4), .WIDTH(32), .MAX_BURST(4)) u_dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ready_o(ready), .fifo_full_i(fifo_full), .fifo_wr_o(fifo_wr),
      .fifo_wr_data_o(wr_data), .grant_id_o(grant), .locked_o(locked)
`ifdef FSFIFO_ARB_STATS_EN
      , .stats_clr_i(stats_clr), .grant_cnt_o(cnt)
`endif
   );

   fsfifo_wr_arbiter #(.NREQ(4), .WIDTH(32), .MAX_BURST(1)) u_rr (
      .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(rr_valid), .req_data_i(req_data),
      .req_ready_o(rr_ready), .fifo_full_i(rr_full), .fifo_wr_o(rr_wr),
      .fifo_wr_data_o(rr_data), .grant_id_o(rr_grant), .locked_o(rr_locked)
`ifdef FSFIFO_ARB_STATS_EN
      , .stats_clr_i(stats_clr), .grant_cnt_o(rr_cnt)
`endif
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [33:0] expw(input int id);
      return {2'(id), 8'(id), 8'h5A, 16'(seq)};
   endfunction

   task automatic drive_data();
      for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = {8'(k), 8'h5A, 16'(seq)};
   endtask

   // One cycle: drive after the edge, queue expected writes, check control outputs.
   task automatic cyc(input logic [3:0] v, input logic fl, input logic [3:0] vr,
                      input int eid, input int eid1, input logic elock, input int egrant);
      @(posedge clk_i); #1;
      seq++;
      drive_data();
      req_valid = v;
      fifo_full = fl;
      rr_valid  = vr;
      if (eid >= 0)  q.push_back(expw(eid));
      if (eid1 >= 0) q1.push_back(expw(eid1));
      #2;
      chk("wr", fifo_wr, eid >= 0);
      chk("grant", grant, egrant);
      chk("locked", locked, elock);
      chk("rr_wr", rr_wr, eid1 >= 0);
      if (eid1 >= 0) chk("rr_grant", rr_grant, eid1);
   endtask

   always @(negedge clk_i) begin
      logic [33:0] w;
      if (fifo_wr) begin
         if (q.size() == 0) chk("sb_unexpected_wr", wr_data, 0);
         else begin
            w = q.pop_front();
            chk("sb_data", wr_data, w);
            chk("sb_ready", ready, 4'b0001 << w[33:32]);
         end
      end
      if (rr_wr) begin
         if (q1.size() == 0) chk("rr_sb_unexpected_wr", rr_data, 0);
         else begin
            w = q1.pop_front();
            chk("rr_sb_data", rr_data, w);
            chk("rr_sb_ready", rr_ready, 4'b0001 << w[33:32]);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_ni  = 1'b0;
      req_valid = 4'hF;
      rr_valid  = 4'hF;
      fifo_full = 1'b0;
      rr_full   = 1'b0;
      stats_clr = 1'b0;
      drive_data();
      #3;
      chk("rst_wr", fifo_wr, 0);
      chk("rst_ready", ready, 0);
      chk("rst_grant", grant, 0);
      chk("rst_locked", locked, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_rr_ready", rr_ready, 0);
      @(posedge clk_i); #1;
      req_valid = 4'h0;
      rr_valid  = 4'h0;
      reset_ni  = 1'b1;

      // pure round-robin instance
      cyc(4'b0000, 0, 4'b1111, -1, 0, 0, 0);
      cyc(4'b0000, 0, 4'b1111, -1, 1, 0, 0);
      cyc(4'b0000, 0, 4'b1111, -1, 2, 0, 0);
      cyc(4'b0000, 0, 4'b1111, -1, 3, 0, 0);
      cyc(4'b0000, 0, 4'b1111, -1, 0, 0, 0);

      // burst of 4 from req1, then req2
      cyc(4'b0110, 0, 4'b0000,  1, -1, 0, 1);
      cyc(4'b0110, 0, 4'b0000,  1, -1, 1, 1);
      cyc(4'b0110, 0, 4'b0000,  1, -1, 1, 1);
      cyc(4'b0110, 0, 4'b0000,  1, -1, 1, 1);
      cyc(4'b0110, 0, 4'b0000,  2, -1, 0, 2);
      cyc(4'b0110, 0, 4'b0000,  2, -1, 1, 2);
      cyc(4'b0010, 0, 4'b0000, -1, -1, 1, 2);
      cyc(4'b0010, 0, 4'b0000,  1, -1, 0, 1);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 1, 1);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 0, 2);

      // full stalls req0 mid-burst
      cyc(4'b0001, 0, 4'b0000,  0, -1, 0, 0);
      cyc(4'b0001, 0, 4'b0000,  0, -1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(4'b1111, 1, 4'b0000, -1, -1, 1, 0);
         chk("full_ready", ready, 0);
      end
      cyc(4'b1111, 0, 4'b0000,  0, -1, 1, 0);
      cyc(4'b1111, 0, 4'b0000,  0, -1, 1, 0);
      cyc(4'b1111, 0, 4'b0000,  1, -1, 0, 1);
      cyc(4'b1111, 0, 4'b0000,  1, -1, 1, 1);
      cyc(4'b1111, 0, 4'b0000,  1, -1, 1, 1);
      cyc(4'b1111, 0, 4'b0000,  1, -1, 1, 1);

      // owner req3 drops mid-burst, pointer wraps to 0
      cyc(4'b1000, 0, 4'b0000,  3, -1, 0, 3);
      cyc(4'b1000, 0, 4'b0000,  3, -1, 1, 3);
      cyc(4'b0101, 0, 4'b0000, -1, -1, 1, 3);
      cyc(4'b0101, 0, 4'b0000,  0, -1, 0, 0);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 1, 0);
      cyc(4'b0101, 1, 4'b0000, -1, -1, 0, 2);
      cyc(4'b0101, 0, 4'b0000,  2, -1, 0, 2);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 1, 2);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 0, 3);

      // asynchronous reset mid-burst
      cyc(4'b1111, 0, 4'b0000,  3, -1, 0, 3);
      cyc(4'b1111, 0, 4'b0000,  3, -1, 1, 3);
      @(posedge clk_i); #1;
      seq++;
      drive_data();
      #1 reset_ni = 1'b0;
      #1;
      chk("arst_wr", fifo_wr, 0);
      chk("arst_ready", ready, 0);
      chk("arst_grant", grant, 0);
      chk("arst_locked", locked, 0);
      chk("arst_data", wr_data, 0);
      @(posedge clk_i);
      @(posedge clk_i); #1;
      req_valid = 4'h0;
      reset_ni  = 1'b1;
      cyc(4'b1111, 0, 4'b0000,  0, -1, 0, 0);
      cyc(4'b1111, 0, 4'b0000,  0, -1, 1, 0);
      cyc(4'b0000, 0, 4'b0000, -1, -1, 1, 0);

`ifdef FSFIFO_ARB_STATS_EN
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk_i); #1;
         seq++;
         drive_data();
         req_valid = 4'b0100;
         q.push_back(expw(2));
      end
      @(posedge clk_i); #1;
      req_valid = 4'b0000;
      #1;
      chk("cnt2_sat", cnt[2*16 +: 16], 16'hFFFF);
      chk("cnt0", cnt[0 +: 16], 2);
      @(posedge clk_i); #1;
      seq++;
      drive_data();
      req_valid = 4'b0100;
      stats_clr = 1'b1;
      q.push_back(expw(2));
      @(posedge clk_i); #1;
      stats_clr = 1'b0;
      req_valid = 4'b0000;
      #1;
      chk("cnt2_clr", cnt[2*16 +: 16], 0);
      chk("cnt0_clr", cnt[0 +: 16], 0);
`endif

      @(posedge clk_i); #1;
      chk("sb_left", q.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
